instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the main control decoder and register file.
- Holds the PC and fetches 32-bit instructions over a valid-qualified instruction-memory handshake.
- Presents the instruction and its opcode field (instr[31:26]) to the decoder.
- Computes the next PC from the sequential, branch-taken and jump inputs that the decode/execute logic returns.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- imem_req  out  1  fetch request, held high until response
- imem_addr  out  32  fetch address (current PC)
- imem_rdata  in  32  instruction word, qualified by imem_valid
- imem_valid  in  1  response strobe; may arrive 0..N cycles after imem_req rises
- instr  out  32  registered instruction
- opcode  out  6  instr[31:26], to the control decoder
- instr_valid  out  1  instr/opcode/pc are valid
- issue_ready  in  1  downstream consumes the instruction this cycle
- pc  out  32  PC of the presented instruction
- pc_plus4  out  32  pc + 4, combinational, mod 2^32
- branch_taken  in  1  Branch AND ALU zero for the presented instruction
- branch_offset  in  32  sign-extended 16-bit immediate
- jump  in  1  presented instruction is J
- jump_index  in  26  instr[25:0] of the jump
- retired_count  out  32  count of accepted instructions, wraps

Behaviour:
- Reset (rst_n=0 at a rising edge), regardless of state:
  - state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC
  - instr=0, opcode=0, instr_valid=0, retired_count=0
  - Any in-flight fetch is abandoned.
- States: IDLE, FETCH, ISSUED.
- IDLE:
  - Lasts exactly one cycle after rst_n deasserts; imem_req=0; imem_valid ignored.
  - Next state: FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc, held stable until imem_valid=1.
  - On imem_valid=1, including the first FETCH cycle (zero-wait): instr<=imem_rdata, instr_valid<=1, next state ISSUED.
  - Otherwise remain in FETCH. No timeout.
- ISSUED:
  - imem_req=0; instr, opcode and pc held stable; imem_valid ignored.
  - issue_ready=0: hold (stall).
  - issue_ready=1 (accept): pc<=next_pc, instr_valid<=0, retired_count<=retired_count+1 (wraps 0xFFFF_FFFF->0), next state FETCH.
- next_pc, evaluated only on an accept cycle:
  - jump=1: {pc_plus4[31:28], jump_index, 2'b00}. Jump has priority over branch_taken.
  - else branch_taken=1: pc_plus4 + (branch_offset << 2), 32-bit wrap, carry discarded.
  - else: pc_plus4.
- Redirect inputs are don't-care when no accept occurs.
- pc[1:0] is always 00 by construction, given an aligned RESET_PC.
- Throughput: at most one instruction per 2 cycles (FETCH plus ISSUED) with zero-wait memory.
- imem_addr updates on the same edge as pc; imem_req rises in the first FETCH cycle after accept.
- opcode is a direct slice of the instr register, never combinational from imem_rdata.
- Memory shares rst_n. A response arriving during IDLE or ISSUED is discarded with no state change.

Test Plan:
- Reset then sequential run: RESET_PC=0, memory returns 1-cycle-latency words, issue_ready=1, no redirects.
  - imem_req rises in cycle 2 after rst_n high.
  - pc sequence 0,4,8,12; opcode matches instr[31:26]; retired_count=4 after 4 accepts.
- Stalls and wait states:
  - issue_ready=0 for 5 cycles in ISSUED: instr, pc and instr_valid stable, imem_req=0, count unchanged.
  - imem_valid delayed 3 cycles: imem_req and imem_addr held stable throughout.
- Branch:
  - pc=0x100, branch_taken=1, branch_offset=0xFFFF_FFFC (-4) -> next pc=0x0F4.
  - branch_offset=0x0000_0003 -> next pc=0x110.
- Jump priority and wrap:
  - pc=0x4000_0010, jump=1, jump_index=0x0000040, branch_taken=1 -> next pc=0x4000_0100.
  - pc=0xFFFF_FFFC, sequential accept -> next pc=0x0000_0000.
- Reset mid-operation:
  - rst_n=0 during FETCH with imem_valid pulsing in the reset cycle: all outputs at reset values, instr stays 0, no capture.
  - imem_valid=1 in the IDLE cycle is ignored.
- Counter wrap:
  - Force retired_count=0xFFFF_FFFF via preload, then accept one instruction -> retired_count=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches one 32-bit word per request over a
// valid-qualified memory handshake and computes the next PC on accept.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        issue_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] retired_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUED = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] retired_count_q;
    logic        req_q;
    logic        instr_valid_q;
    logic [31:0] pc_plus4_s;
    logic [31:0] next_pc_d;

    // Next-PC selection; jump outranks a taken branch, offset is a word count.
    always_comb begin
        pc_plus4_s = pc_q + 32'd4;
        next_pc_d  = pc_plus4_s;
        if (jump) begin
            next_pc_d = {pc_plus4_s[31:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            next_pc_d = pc_plus4_s + {branch_offset[29:0], 2'b00};
        end else begin
            next_pc_d = pc_plus4_s;
        end
    end

    // Fetch FSM with all outputs registered; responses outside FETCH are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            pc_q            <= RESET_PC;
            instr_q         <= 32'h0000_0000;
            retired_count_q <= 32'h0000_0000;
            req_q           <= 1'b0;
            instr_valid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: begin
                    if (imem_valid) begin
                        instr_q       <= imem_rdata;
                        instr_valid_q <= 1'b1;
                        req_q         <= 1'b0;
                        state_q       <= ISSUED;
                    end else begin
                        req_q   <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                ISSUED: begin
                    if (issue_ready) begin
                        pc_q            <= next_pc_d;
                        instr_valid_q   <= 1'b0;
                        retired_count_q <= retired_count_q + 32'd1;
                        req_q           <= 1'b1;
                        state_q         <= FETCH;
                    end else begin
                        req_q   <= 1'b0;
                        state_q <= ISSUED;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    req_q         <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = pc_q;
    assign instr         = instr_q;
    assign opcode        = instr_q[31:26];
    assign instr_valid   = instr_valid_q;
    assign pc            = pc_q;
    assign pc_plus4      = pc_plus4_s;
    assign retired_count = retired_count_q;

endmodule
